// File: rtl/dec16_rr_arbiter.sv
// Round-robin arbiter for 16 requesters sharing a 4-to-16 decoded select bus.
// Registered grant index, one-hot decode, tenure limit and timeout pulse.
module dec16_rr_arbiter #(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    // "release" is a reserved word in SystemVerilog, hence this name
    input  logic        release_grant,
    output logic        grant_valid,
    output logic [3:0]  grant_idx,
    output logic [15:0] grant_oh,
    output logic        timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TOP  = {CNT_W{1'b1}};

    state_t            state, state_nxt;
    logic [3:0]        ptr, ptr_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              valid_nxt;
    logic [3:0]        idx_nxt;
    logic [15:0]       oh_nxt;
    logic              timeout_nxt;

    logic              end_rel;
    logic              end_drop;
    logic              end_hold;

    // First set bit at or after p, searching upward with wrap.
    function automatic logic [3:0] pick(input logic [15:0] r, input logic [3:0] p);
        logic [31:0] dbl;
        logic [15:0] rot;
        logic [3:0]  off;
        dbl = {r, r};
        rot = 16'(dbl >> p);
        off = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (rot[i]) begin
                off = 4'(i);
            end
        end
        return p + off;
    endfunction

    function automatic logic [15:0] decode(input logic en, input logic [3:0] idx);
        logic [15:0] d;
        d = 16'h0000;
        if (en) begin
            d[idx] = 1'b1;
        end
        return d;
    endfunction

    assign end_rel  = release_grant;
    assign end_drop = ~req[grant_idx];
    assign end_hold = (HOLD_MAX != 0) && (cnt == HOLD_LIM);

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        cnt_nxt     = cnt;
        valid_nxt   = grant_valid;
        idx_nxt     = grant_idx;
        timeout_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (|req) begin
                    idx_nxt   = pick(req, ptr);
                    valid_nxt = 1'b1;
                    cnt_nxt   = CNT_ONE;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (end_rel || end_drop || end_hold) begin
                    valid_nxt   = 1'b0;
                    idx_nxt     = 4'd0;
                    cnt_nxt     = '0;
                    ptr_nxt     = grant_idx + 4'd1;
                    state_nxt   = IDLE;
                    timeout_nxt = end_hold && !end_rel && !end_drop;
                end else if (cnt != CNT_TOP) begin
                    // saturate so a disabled limit never wraps the counter
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
                idx_nxt   = 4'd0;
                cnt_nxt   = '0;
            end
        endcase

        oh_nxt = decode(valid_nxt, idx_nxt);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= 4'd0;
            cnt         <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= 4'd0;
            grant_oh    <= 16'h0000;
            timeout     <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            cnt         <= cnt_nxt;
            grant_valid <= valid_nxt;
            grant_idx   <= idx_nxt;
            grant_oh    <= oh_nxt;
            timeout     <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_dec16_rr_arbiter.sv
// Directed self-checking bench for dec16_rr_arbiter with a 4-cycle tenure limit.
module tb_dec16_rr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [15:0] req;
    logic        release_grant;
    logic        grant_valid;
    logic [3:0]  grant_idx;
    logic [15:0] grant_oh;
    logic        timeout;

    int checks;
    int errors;

    dec16_rr_arbiter #(
        .HOLD_MAX(4),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .release_grant(release_grant),
        .grant_valid(grant_valid),
        .grant_idx(grant_idx),
        .grant_oh(grant_oh),
        .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = 16'h0000;
        release_grant = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = 16'hFFFF;
        release_grant = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (grant_valid !== 1'b0 || grant_oh !== 16'h0000 || timeout !== 1'b0 || grant_idx !== 4'd0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: valid=%0b idx=%0d oh=%h timeout=%0b, expected all zero",
                         c, grant_valid, grant_idx, grant_oh, timeout);
            end
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (grant_valid !== 1'b1 || grant_idx !== 4'd0 || grant_oh !== 16'h0001 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_grant: valid=%0b idx=%0d oh=%h timeout=%0b, expected valid=1 idx=0 oh=0001 timeout=0",
                     grant_valid, grant_idx, grant_oh, timeout);
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 16'h0020;
        for (int c = 1; c <= 3; c++) begin
            step();
            checks++;
            if (grant_valid !== 1'b1 || grant_idx !== 4'd5 || grant_oh !== 16'h0020 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL single_grant[%0d]: valid=%0b idx=%0d oh=%h timeout=%0b, expected valid=1 idx=5 oh=0020 timeout=0",
                         c, grant_valid, grant_idx, grant_oh, timeout);
            end
        end
        release_grant = 1'b1;
        step();
        release_grant = 1'b0;
        checks++;
        if (grant_valid !== 1'b0 || grant_idx !== 4'd0 || grant_oh !== 16'h0000 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL single_gap: valid=%0b idx=%0d oh=%h timeout=%0b, expected all zero",
                     grant_valid, grant_idx, grant_oh, timeout);
        end
        step();
        checks++;
        if (grant_valid !== 1'b1 || grant_idx !== 4'd5 || grant_oh !== 16'h0020) begin
            errors++;
            $display("FAIL single_regrant: valid=%0b idx=%0d oh=%h, expected valid=1 idx=5 oh=0020",
                     grant_valid, grant_idx, grant_oh);
        end
        req = 16'h0000;
        step();
        checks++;
        if (grant_valid !== 1'b0 || grant_oh !== 16'h0000 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL single_drop: valid=%0b oh=%h timeout=%0b, expected valid=0 oh=0000 timeout=0",
                     grant_valid, grant_oh, timeout);
        end
    endtask

    task automatic test_rotation();
        logic [3:0]  exp_idx;
        logic [15:0] exp_oh;
        do_reset();
        req = 16'hFFFF;
        release_grant = 1'b1;
        for (int i = 0; i < 18; i++) begin
            exp_idx = 4'(i % 16);
            exp_oh = 16'h0001 << exp_idx;
            step();
            checks++;
            if (grant_valid !== 1'b1 || grant_idx !== exp_idx || grant_oh !== exp_oh) begin
                errors++;
                $display("FAIL rotation_grant[%0d]: valid=%0b idx=%0d oh=%h, expected valid=1 idx=%0d oh=%h",
                         i, grant_valid, grant_idx, grant_oh, exp_idx, exp_oh);
            end
            step();
            checks++;
            if (grant_valid !== 1'b0 || grant_oh !== 16'h0000 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL rotation_gap[%0d]: valid=%0b oh=%h timeout=%0b, expected valid=0 oh=0000 timeout=0",
                         i, grant_valid, grant_oh, timeout);
            end
        end
        release_grant = 1'b0;
    endtask

    task automatic test_timeout();
        logic [3:0] owners [3];
        owners[0] = 4'd0;
        owners[1] = 4'd15;
        owners[2] = 4'd0;
        do_reset();
        req = 16'h8001;
        for (int g = 0; g < 2; g++) begin
            step();
            for (int c = 1; c <= 4; c++) begin
                checks++;
                if (grant_valid !== 1'b1 || grant_idx !== owners[g] || timeout !== 1'b0) begin
                    errors++;
                    $display("FAIL timeout_tenure[%0d.%0d]: valid=%0b idx=%0d timeout=%0b, expected valid=1 idx=%0d timeout=0",
                             g, c, grant_valid, grant_idx, timeout, owners[g]);
                end
                step();
            end
            checks++;
            if (grant_valid !== 1'b0 || timeout !== 1'b1 || grant_oh !== 16'h0000) begin
                errors++;
                $display("FAIL timeout_pulse[%0d]: valid=%0b timeout=%0b oh=%h, expected valid=0 timeout=1 oh=0000",
                         g, grant_valid, timeout, grant_oh);
            end
        end
        step();
        checks++;
        if (grant_valid !== 1'b1 || grant_idx !== owners[2] || timeout !== 1'b0 || grant_oh !== 16'h0001) begin
            errors++;
            $display("FAIL timeout_wrap: valid=%0b idx=%0d timeout=%0b oh=%h, expected valid=1 idx=0 timeout=0 oh=0001",
                     grant_valid, grant_idx, timeout, grant_oh);
        end
    endtask

    task automatic test_skip_coincide();
        do_reset();
        req = 16'h0004;
        step();
        checks++;
        if (grant_valid !== 1'b1 || grant_idx !== 4'd2) begin
            errors++;
            $display("FAIL skip_first: valid=%0b idx=%0d, expected valid=1 idx=2", grant_valid, grant_idx);
        end
        req = 16'h0104;
        release_grant = 1'b1;
        step();
        release_grant = 1'b0;
        step();
        checks++;
        if (grant_valid !== 1'b1 || grant_idx !== 4'd8 || grant_oh !== 16'h0100) begin
            errors++;
            $display("FAIL skip_to_8: valid=%0b idx=%0d oh=%h, expected valid=1 idx=8 oh=0100",
                     grant_valid, grant_idx, grant_oh);
        end
        step();
        step();
        step();
        release_grant = 1'b1;
        step();
        release_grant = 1'b0;
        checks++;
        if (grant_valid !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL coincide_no_timeout: valid=%0b timeout=%0b, expected valid=0 timeout=0",
                     grant_valid, timeout);
        end
        step();
        checks++;
        if (grant_valid !== 1'b1 || grant_idx !== 4'd2 || grant_oh !== 16'h0004) begin
            errors++;
            $display("FAIL skip_back_to_2: valid=%0b idx=%0d oh=%h, expected valid=1 idx=2 oh=0004",
                     grant_valid, grant_idx, grant_oh);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 16'h0200;
        step();
        step();
        checks++;
        if (grant_valid !== 1'b1 || grant_idx !== 4'd9) begin
            errors++;
            $display("FAIL midreset_grant: valid=%0b idx=%0d, expected valid=1 idx=9", grant_valid, grant_idx);
        end
        rst_n = 1'b0;
        step();
        checks++;
        if (grant_valid !== 1'b0 || grant_idx !== 4'd0 || grant_oh !== 16'h0000 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL midreset_clear: valid=%0b idx=%0d oh=%h timeout=%0b, expected all zero",
                     grant_valid, grant_idx, grant_oh, timeout);
        end
        rst_n = 1'b1;
        req = 16'h0201;
        step();
        checks++;
        if (grant_valid !== 1'b1 || grant_idx !== 4'd0 || grant_oh !== 16'h0001) begin
            errors++;
            $display("FAIL midreset_ptr: valid=%0b idx=%0d oh=%h, expected valid=1 idx=0 oh=0001",
                     grant_valid, grant_idx, grant_oh);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        req = 16'h0000;
        release_grant = 1'b0;
        test_reset();
        test_single();
        test_rotation();
        test_timeout();
        test_skip_coincide();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
